// File: rtl/regfile_write_demux_pkg.sv
// ============================================================================
// regfile_write_demux_pkg : shared constants for the register-file write side
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_write_demux_pkg;

  localparam int               REG_ADDR_W = 5;
  localparam int               NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

endpackage

`default_nettype wire

// File: rtl/regfile_write_demux_decoder5to32_en.sv
// ============================================================================
// decoder5to32_en : 5-bit address to 32-bit one-hot decoder with enable
// Rev 1.0
// ============================================================================
`default_nettype none

module decoder5to32_en
  import regfile_write_demux_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [NUM_REGS-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_demux.sv
// ============================================================================
// regfile_write_demux : write-back decode, 32 x N register bank, pending scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_write_demux
  import regfile_write_demux_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREG = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic                  rsv_en,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic [NREG*N-1:0]     regs_flat,
  output logic [NREG-1:0]       pending,
  output logic [NREG-1:0]       wr_onehot
);

  localparam logic [NUM_REGS-1:0] ZERO_MASK = NUM_REGS'(1) << ZERO_REG;

  logic [NUM_REGS-1:0] wr_raw;
  logic [NUM_REGS-1:0] rsv_raw;
  logic [NUM_REGS-1:0] wr_dec;
  logic [NUM_REGS-1:0] rsv_dec;

  decoder5to32_en u_wr_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (wr_raw)
  );

  decoder5to32_en u_rsv_dec (
    .en     (rsv_en),
    .addr   (rsv_addr),
    .onehot (rsv_raw)
  );

  // XZR is masked out at the decode so it can never be written or reserved
  assign wr_dec  = wr_raw  & ~ZERO_MASK;
  assign rsv_dec = rsv_raw & ~ZERO_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_onehot <= '0;
    end else begin
      wr_onehot <= wr_dec;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    if (k == int'(ZERO_REG)) begin : g_zero
      assign regs_flat[k*N +: N] = '0;
    end else begin : g_live
      logic [N-1:0] q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (wr_dec[k]) begin
          q <= wr_data;
        end
      end
      assign regs_flat[k*N +: N] = q;
    end
  end

  // Reserve wins over write-back: the new reservation belongs to a younger instruction
  for (genvar k = 0; k < NREG; k++) begin : g_pend
    always_ff @(posedge clk) begin
      if (reset) begin
        pending[k] <= 1'b0;
      end else if (rsv_dec[k]) begin
        pending[k] <= 1'b1;
      end else if (wr_dec[k]) begin
        pending[k] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_demux.md
Name: regfile_write_demux

Overview:
- Write-side counterpart of the 32:1 register read muxes. Decodes a 5-bit write address into one-hot enables and stores write-back data into a 32 x N register bank.
- Exposes the bank as a flat bus. The existing Mux32to1Nbit instances select from this bus for operand reads.
- Keeps a per-register pending scoreboard: a register is reserved at issue and released when write-back lands.
- Register 31 is the hardwired zero register (XZR).

Parameters:
- N, 64, data width of each register.
- NREG, 32, register count. Fixed at 32; address width is 5.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write-back strobe.
- wr_addr  input  5  write-back destination register.
- wr_data  input  N  write-back data.
- rsv_en  input  1  reserve (mark pending) strobe from issue.
- rsv_addr  input  5  register to reserve.
- regs_flat  output  32*N  register contents; register k occupies bits [k*N+N-1 : k*N].
- pending  output  32  scoreboard; bit k=1 means register k awaits write-back.
- wr_onehot  output  32  registered one-hot of the last accepted write, for debug and forwarding.

Behaviour:
- One clock domain. Reset is synchronous and active-high: all state updates only on the rising edge of clk, and reset is sampled there.
- Reset: all 32 registers = 0, pending = 0, wr_onehot = 0.
- Reset has priority over wr_en and rsv_en in the same cycle.
- Reset asserted mid-operation discards any in-flight write; no partial update.
- Decode: dec = wr_en ? (1 << wr_addr) : 0, with bit 31 forced to 0.
- Write: on edge, each register k with dec[k]=1 loads wr_data. All other registers hold.
- Write latency: one cycle. Data presented at edge t appears on regs_flat after edge t.
- There is no internal read bypass. Forwarding uses wr_onehot plus the external wr_data pipeline.
- wr_onehot <= dec every cycle. It is zero on cycles without a valid write, and zero for writes to register 31.
- Register 31: the slice always reads 0. Writes to it are dropped, it is never pending, and rsv_addr=31 is ignored.
- Scoreboard, per bit k (k < 31), at each edge:
  - set if rsv_en and rsv_addr==k;
  - else clear if wr_en and wr_addr==k;
  - else hold.
- Simultaneous reserve and write to the same register: data is written AND pending stays 1. The new reservation belongs to a younger instruction.
- Reserve and write to different registers in the same cycle: both take effect independently.
- Write to a non-pending register is legal. Data loads and pending stays 0.
- Reserve of an already-pending register is legal; pending stays 1. There is no counting, so a single write-back clears it.
- No full/empty conditions. All 32 bits may be pending simultaneously.

Decomposition:
- Shared package constants: REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd31.
- One sub-module: decoder5to32_en. Inputs are en and addr[4:0]; output is a 32-bit one-hot.
- The decoder is instantiated twice: once for the write path, once for the reserve path.
- The register bank and scoreboard are generate loops in the top module.

Test Plan:
- Reset, then idle 3 cycles -> regs_flat all 0, pending = 32'h0, wr_onehot = 0.
- wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF_0000_0005 -> next cycle the reg 5 slice equals that value, wr_onehot = 32'h0000_0020, all other slices unchanged.
- wr_en=1, wr_addr=31, wr_data=64'hFFFF_FFFF_FFFF_FFFF -> the reg 31 slice stays 0, wr_onehot = 0. rsv_en=1, rsv_addr=31 -> pending[31] stays 0.
- rsv_en=1, rsv_addr=7 -> pending = 32'h80. Two cycles later wr_en=1, wr_addr=7, wr_data=64'h7 -> pending = 0 and the reg 7 slice = 64'h7.
- Same-cycle rsv_addr=3 and wr_addr=3 with reg 3 already pending, wr_data=64'h33 -> reg 3 = 64'h33 and pending[3] stays 1.
- Reg 10 written to 64'hA and pending[2] set; then reset asserted in the same cycle as wr_en=1, wr_addr=10, wr_data=64'hB -> next cycle all registers 0, pending = 0, wr_onehot = 0.
